ahb_timer_slave: RTL and testbench

AHB-Lite responder peripheral for the Cortex-M0 system. It implements a 32-bit down-counting timer that the CPU programs over the bus. On expiry it raises a level interrupt (`TIMER_IRQ`) and a single-cycle event pulse (`RXEV`). It sits on the system AHB-Lite bus alongside memory, and its outputs feed the CPU's IRQ and RXEV inputs in `system_top`, which makes it the inbound counterpart to the CPU's TXEV event output.

---
 rtl/ahb_timer_pkg.sv | 23 ++
 rtl/ahb_timer_core.sv | 36 +++
 rtl/ahb_timer_slave.sv | 127 ++++++++++++
 tb/tb_ahb_timer_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_timer_pkg.sv
// Shared constants for the AHB-Lite timer slave: register offsets, CTRL bit
// positions and the bus encodings the address phase decodes.
package ahb_timer_pkg;

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_LOAD   = 2'd1;
    localparam logic [1:0] OFS_VALUE  = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQEN  = 1;
    localparam int CTRL_RELOAD = 2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_timer_core.sv
// Down-counter with reload and expiry detection; a bus LOAD write always
// overrides whatever the counter would otherwise do that cycle.
module ahb_timer_core
    import ahb_timer_pkg::*;
#(
    parameter logic [31:0] RST_LOAD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        reload,
    input  logic [31:0] reload_value,
    input  logic        load_we,
    input  logic [31:0] load_data,
    output logic [31:0] value,
    output logic        expire
);

    assign expire = enable && (value == 32'd0);

    // Without reload, an expired counter just sits at zero until reprogrammed.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= RST_LOAD;
        end else if (load_we) begin
            value <= load_data;
        end else if (expire) begin
            if (reload) begin
                value <= reload_value;
            end
        end else if (enable) begin
            value <= value - 32'd1;
        end
    end

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB-Lite responder wrapping the timer core: address/data-phase pipeline,
// register decode, W1C status flag and the RXEV event pulse.
module ahb_timer_slave
    import ahb_timer_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RST_LOAD = 32'h0000_0000
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              TIMER_IRQ,
    output logic              RXEV
);

    logic        dp_valid;
    logic        dp_write;
    logic [1:0]  dp_addr;
    logic [2:0]  ctrl;
    logic [31:0] load_reg;
    logic [31:0] value;
    logic        exp_flag;
    logic        expire;
    logic        accept;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        unused_bits;

    assign accept = HSEL && HREADY && HTRANS[1] && (HSIZE == HSIZE_WORD);

    // Only the word-select bits and the active/idle bit of HTRANS matter.
    assign unused_bits = ^{HADDR, HTRANS};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= OFS_CTRL;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[3:2];
            end
        end
    end

    assign wr_ctrl   = dp_valid && dp_write && (dp_addr == OFS_CTRL);
    assign wr_load   = dp_valid && dp_write && (dp_addr == OFS_LOAD);
    assign wr_status = dp_valid && dp_write && (dp_addr == OFS_STATUS);

    // A CTRL write beats the auto-clear of EN on a non-reloading expiry.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl <= 3'b000;
        end else if (wr_ctrl) begin
            ctrl <= HWDATA[2:0];
        end else if (expire && !ctrl[CTRL_RELOAD]) begin
            ctrl[CTRL_EN] <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            load_reg <= RST_LOAD;
        end else if (wr_load) begin
            load_reg <= HWDATA;
        end
    end

    // Setting on expiry takes priority over a simultaneous W1C.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            exp_flag <= 1'b0;
            RXEV     <= 1'b0;
        end else begin
            RXEV <= expire;
            if (expire) begin
                exp_flag <= 1'b1;
            end else if (wr_status && HWDATA[0]) begin
                exp_flag <= 1'b0;
            end
        end
    end

    ahb_timer_core #(
        .RST_LOAD (RST_LOAD)
    ) u_core (
        .clk          (HCLK),
        .reset        (HRESET),
        .enable       (ctrl[CTRL_EN]),
        .reload       (ctrl[CTRL_RELOAD]),
        .reload_value (load_reg),
        .load_we      (wr_load),
        .load_data    (HWDATA),
        .value        (value),
        .expire       (expire)
    );

    always_comb begin
        HRDATA = 32'd0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                OFS_CTRL:   HRDATA = {29'd0, ctrl};
                OFS_LOAD:   HRDATA = load_reg;
                OFS_VALUE:  HRDATA = value;
                OFS_STATUS: HRDATA = {31'd0, exp_flag};
                default:    HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign TIMER_IRQ = exp_flag && ctrl[CTRL_IRQEN];

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Self-checking bench for ahb_timer_slave: bus reads push their expected data
// into a scoreboard that a negedge monitor pops during each read data phase.
module tb_ahb_timer_slave;
    import ahb_timer_pkg::*;

    localparam logic [31:0] RST_LOAD = 32'h0000_0000;
    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_LOAD   = 12'h004;
    localparam logic [11:0] A_VALUE  = 12'h008;
    localparam logic [11:0] A_STATUS = 12'h00C;

    logic        sim_clock;
    logic        HRESET;
    logic        HSEL;
    logic [11:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        TIMER_IRQ;
    logic        RXEV;

    int          check_count;
    int          fail_count;
    logic        monitor_on;
    logic        read_pending;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    ahb_timer_slave #(
        .ADDR_W   (12),
        .RST_LOAD (RST_LOAD)
    ) dut (
        .HCLK      (sim_clock),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .TIMER_IRQ (TIMER_IRQ),
        .RXEV      (RXEV)
    );

    initial sim_clock = 1'b0;
    always #5 sim_clock = ~sim_clock;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Bench-side view of which cycles carry a read data phase.
    always @(posedge sim_clock) begin
        if (HRESET)
            read_pending <= 1'b0;
        else
            read_pending <= HSEL && HREADY && HTRANS[1] && !HWRITE && (HSIZE == HSIZE_WORD);
    end

    always @(negedge sim_clock) begin
        if (monitor_on && !HRESET) begin
            check_output("hreadyout", 32'(HREADYOUT), 32'd1);
            check_output("hresp", 32'(HRESP), 32'd0);
            if (read_pending) begin
                if (exp_q.size() == 0) begin
                    check_output("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_output(tag_q.pop_front(), HRDATA, exp_q.pop_front());
                end
            end else begin
                check_output("hrdata_idle", HRDATA, 32'd0);
            end
        end
    end

    task automatic apply_stimulus(input logic [11:0] addr, input logic write,
                                  input logic [2:0] size, input logic [1:0] trans,
                                  input logic sel);
        HSEL   = sel;
        HADDR  = addr;
        HWRITE = write;
        HSIZE  = size;
        HTRANS = trans;
        @(posedge sim_clock);
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(12'h000, 1'b0, HSIZE_WORD, HTRANS_IDLE, 1'b0);
    endtask

    task automatic write_reg(input logic [11:0] addr, input logic [31:0] data);
        apply_stimulus(addr, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 1'b1);
        HWDATA = data;
        idle_cycle();
    endtask

    task automatic read_expect(input logic [11:0] addr, input logic [31:0] expected,
                               input string tag);
        exp_q.push_back(expected);
        tag_q.push_back(tag);
        apply_stimulus(addr, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 1'b1);
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        monitor_on  = 1'b0;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 12'h000;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HSIZE  = HSIZE_WORD;
        HWDATA = 32'd0;
        HREADY = 1'b1;
        repeat (2) @(posedge sim_clock);
        #1;
        HRESET = 1'b0;
        monitor_on = 1'b1;

        check_output("rst_rxev", 32'(RXEV), 32'd0);
        check_output("rst_irq", 32'(TIMER_IRQ), 32'd0);
        check_output("rst_hrdata", HRDATA, 32'd0);
        read_expect(A_CTRL, 32'd0, "rst_ctrl");
        read_expect(A_LOAD, RST_LOAD, "rst_load");
        read_expect(A_VALUE, RST_LOAD, "rst_value");
        read_expect(A_STATUS, 32'd0, "rst_status");
        idle_cycle();

        // One-shot countdown with back-to-back VALUE reads behind the CTRL write.
        write_reg(A_LOAD, 32'd5);
        apply_stimulus(A_CTRL, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 1'b1);
        HWDATA = 32'h3;
        for (int k = 0; k <= 6; k++) begin
            read_expect(A_VALUE, (k <= 5) ? 32'(5 - k) : 32'd0, "value_count");
            check_output("oneshot_rxev", 32'(RXEV), (k == 6) ? 32'd1 : 32'd0);
            check_output("oneshot_irq", 32'(TIMER_IRQ), (k == 6) ? 32'd1 : 32'd0);
        end
        idle_cycle();
        check_output("oneshot_rxev_end", 32'(RXEV), 32'd0);
        check_output("oneshot_irq_hold", 32'(TIMER_IRQ), 32'd1);
        read_expect(A_CTRL, 32'h2, "oneshot_ctrl");
        read_expect(A_VALUE, 32'd0, "oneshot_value");
        read_expect(A_STATUS, 32'd1, "oneshot_status");
        idle_cycle();

        // Periodic mode without interrupt: pulse every LOAD+1 cycles.
        write_reg(A_STATUS, 32'd1);
        write_reg(A_LOAD, 32'd3);
        write_reg(A_CTRL, 32'h5);
        for (int c = 1; c <= 20; c++) begin
            check_output("reload_rxev", 32'(RXEV), (c >= 5 && (c % 4) == 1) ? 32'd1 : 32'd0);
            check_output("reload_irq", 32'(TIMER_IRQ), 32'd0);
            idle_cycle();
        end
        write_reg(A_CTRL, 32'h0);
        write_reg(A_STATUS, 32'd1);
        read_expect(A_STATUS, 32'd0, "reload_cleared");
        idle_cycle();

        // W1C lands in the same cycle as expiry; set must win.
        write_reg(A_LOAD, 32'd2);
        write_reg(A_CTRL, 32'h3);
        idle_cycle();
        apply_stimulus(A_STATUS, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 1'b1);
        HWDATA = 32'd1;
        idle_cycle();
        check_output("collide_rxev", 32'(RXEV), 32'd1);
        check_output("collide_irq", 32'(TIMER_IRQ), 32'd1);
        read_expect(A_STATUS, 32'd1, "collide_status");
        idle_cycle();
        write_reg(A_STATUS, 32'd1);
        check_output("w1c_irq", 32'(TIMER_IRQ), 32'd0);
        read_expect(A_STATUS, 32'd0, "w1c_status");
        idle_cycle();

        // Transfers that must leave every register untouched.
        apply_stimulus(A_LOAD, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 1'b1);
        HWDATA = 32'h0000_1234;
        apply_stimulus(A_LOAD, 1'b1, HSIZE_WORD, HTRANS_IDLE, 1'b1);
        HWDATA = 32'h0000_5678;
        apply_stimulus(A_LOAD, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 1'b0);
        HWDATA = 32'h0000_9ABC;
        write_reg(A_VALUE, 32'd77);
        read_expect(A_LOAD, 32'd2, "ignored_load");
        read_expect(A_VALUE, 32'd0, "ignored_value");
        read_expect(A_CTRL, 32'h2, "ignored_ctrl");
        read_expect(A_STATUS, 32'd0, "ignored_status");
        idle_cycle();

        // Reset arrives during the data phase of a LOAD write.
        apply_stimulus(A_LOAD, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 1'b1);
        HWDATA = 32'h0000_DEAD;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HRESET = 1'b1;
        @(posedge sim_clock);
        #1;
        HRESET = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_output("reset_rxev", 32'(RXEV), 32'd0);
            idle_cycle();
        end
        read_expect(A_LOAD, RST_LOAD, "reset_load");
        read_expect(A_VALUE, RST_LOAD, "reset_value");
        read_expect(A_CTRL, 32'd0, "reset_ctrl");
        idle_cycle();
        idle_cycle();
        check_output("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
